// File: rtl/score_keeper.sv
// Two-player IR ball-toss score keeper: synchronizes and debounces six sensors,
// awards points on debounced rising edges and runs the IDLE/PLAY/OVER game FSM.
module score_keeper #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned PTS_S0          = 1,
  parameter int unsigned PTS_S1          = 2,
  parameter int unsigned PTS_S2          = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] ir_sensor_p1,
  input  logic [2:0] ir_sensor_p2,
  input  logic       clock_stopped,
  output logic [5:0] score_p1,
  output logic [5:0] score_p2,
  output logic       score_valid,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int unsigned   CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0]    P0       = 7'(PTS_S0);
  localparam logic [6:0]    P1       = 7'(PTS_S1);
  localparam logic [6:0]    P2       = 7'(PTS_S2);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, OVER = 2'd2} state_e;

  logic [5:0]    raw;
  logic [5:0]    sync1_q, sync2_q;
  logic [5:0]    deb_q, deb_d, deb_prev_q;
  logic [5:0]    hit_q;
  logic [CW-1:0] cnt_q [6];
  logic [CW-1:0] cnt_d [6];
  logic [1:0]    rel_q;
  state_e        state_q;
  logic [5:0]    score1_q, score2_q, score1_d, score2_d;
  logic          valid_q, over_q;
  logic [1:0]    winner_q;

  // One ball per toss: only the highest-index sensor hit counts.
  function automatic logic [6:0] pts_of(input logic [2:0] hit);
    logic [6:0] p;
    if (hit[2])      p = P2;
    else if (hit[1]) p = P1;
    else if (hit[0]) p = P0;
    else             p = 7'd0;
    return p;
  endfunction

  function automatic logic [5:0] sat_add(input logic [5:0] s, input logic [6:0] p);
    logic [6:0] sum;
    sum = {1'b0, s} + p;
    return (sum > 7'd63) ? 6'd63 : sum[5:0];
  endfunction

  assign raw = {ir_sensor_p2, ir_sensor_p1};

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 6; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Sensor path: 2-flop sync, debounce, registered rising-edge hit pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      hit_q      <= '0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      hit_q      <= deb_q & ~deb_prev_q;
      for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign score1_d = sat_add(score1_q, pts_of(hit_q[2:0]));
  assign score2_d = sat_add(score2_q, pts_of(hit_q[5:3]));

  // Reset release is synchronized here so the FSM only leaves IDLE cleanly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rel_q <= '0;
    else          rel_q <= {rel_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      score1_q <= '0;
      score2_q <= '0;
      valid_q  <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= 2'b00;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rel_q[1] && (deb_q == 6'd0) && !clock_stopped) state_q <= PLAY;
        end
        PLAY: begin
          if (clock_stopped) begin
            state_q <= OVER;
            over_q  <= 1'b1;
            if (score1_q > score2_q)      winner_q <= 2'b01;
            else if (score2_q > score1_q) winner_q <= 2'b10;
            else                          winner_q <= 2'b11;
          end else begin
            score1_q <= score1_d;
            score2_q <= score2_d;
            valid_q  <= (score1_d != score1_q) || (score2_d != score2_q);
          end
        end
        OVER:    state_q <= OVER;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign score_p1    = score1_q;
  assign score_p2    = score2_q;
  assign score_valid = valid_q;
  assign game_over   = over_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with a cycle-level behavioural game model
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_score_keeper;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] p1 = 3'b000;
  logic [2:0] p2 = 3'b000;
  logic       cs = 1'b0;
  logic [5:0] score_p1, score_p2;
  logic       score_valid, game_over;
  logic [1:0] winner;

  int errors = 0;
  int checks = 0;
  int vcount = 0;

  score_keeper #(.DEBOUNCE_CYCLES(N), .PTS_S0(1), .PTS_S1(2), .PTS_S2(3)) dut (
    .clk(clk), .reset_n(reset_n), .ir_sensor_p1(p1), .ir_sensor_p2(p2),
    .clock_stopped(cs), .score_p1(score_p1), .score_p2(score_p2),
    .score_valid(score_valid), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: samples history, run-length acceptance, plain arithmetic.
  logic [5:0] rq[$];
  logic [5:0] m_acc, m_accp, m_hit;
  int m_state, m_s1, m_s2, m_valid, m_go, m_win, m_rel;

  function automatic int pts(input logic [2:0] h);
    if (h[2]) return 3;
    if (h[1]) return 2;
    if (h[0]) return 1;
    return 0;
  endfunction

  function automatic int sat63(input int v);
    return (v > 63) ? 63 : v;
  endfunction

  task automatic model_reset();
    rq.delete();
    for (int k = 0; k < N + 2; k++) rq.push_back(6'd0);
    m_acc = '0; m_accp = '0; m_hit = '0;
    m_state = 0; m_s1 = 0; m_s2 = 0; m_valid = 0; m_go = 0; m_win = 0; m_rel = 0;
  endtask

  task automatic model_step();
    logic [5:0] nacc, nhit, smp;
    int ns1, ns2;
    bit all_diff;
    rq.push_back({p2, p1});
    if (rq.size() > N + 2) void'(rq.pop_front());
    // A level is accepted once N consecutive synchronized samples disagree with it.
    nacc = m_acc;
    for (int i = 0; i < 6; i++) begin
      all_diff = 1'b1;
      for (int m = 0; m < N; m++) begin
        smp = rq[rq.size() - 3 - m];
        if (smp[i] == m_acc[i]) all_diff = 1'b0;
      end
      if (all_diff) nacc[i] = ~m_acc[i];
    end
    m_valid = 0;
    case (m_state)
      0: if (m_rel >= 2 && m_acc == 6'd0 && !cs) m_state = 1;
      1: begin
        if (cs) begin
          m_state = 2;
          m_go = 1;
          m_win = (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 3;
        end else begin
          ns1 = sat63(m_s1 + pts(m_hit[2:0]));
          ns2 = sat63(m_s2 + pts(m_hit[5:3]));
          m_valid = (ns1 != m_s1 || ns2 != m_s2) ? 1 : 0;
          m_s1 = ns1;
          m_s2 = ns2;
        end
      end
      default: ;
    endcase
    nhit   = m_acc & ~m_accp;
    m_accp = m_acc;
    m_acc  = nacc;
    m_hit  = nhit;
    if (m_rel < 100) m_rel++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk); #1;
      if (!reset_n) model_reset();
      else          model_step();
      if (score_valid) vcount++;
      chk("model_score_p1", score_p1, m_s1);
      chk("model_score_p2", score_p2, m_s2);
      chk("model_score_valid", score_valid, m_valid);
      chk("model_game_over", game_over, m_go);
      chk("model_winner", winner, m_win);
    end
  end

  task automatic toss(input logic [2:0] a, input logic [2:0] b);
    @(negedge clk); p1 = a; p2 = b;
    repeat (8) @(negedge clk);
    p1 = 3'b000; p2 = 3'b000;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk); reset_n = 1'b0; cs = 1'b0; p1 = 3'b000; p2 = 3'b000;
    repeat (cyc) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_score_p1", score_p1, 0);
    chk("rst_score_p2", score_p2, 0);
    chk("rst_valid", score_valid, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_winner", winner, 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Clean hit on P1 S0: score visible on the 8th rising edge after the edge.
    vcount = 0;
    @(negedge clk); p1 = 3'b001;
    repeat (7) @(posedge clk); #1;
    chk("clean_before", score_p1, 0);
    @(posedge clk); #1;
    chk("clean_at8", score_p1, 1);
    chk("clean_valid", score_valid, 1);
    repeat (12) @(negedge clk); p1 = 3'b000;
    repeat (10) @(negedge clk);
    chk("clean_pulses", vcount, 1);
    chk("clean_p2", score_p2, 0);

    // Bouncing P2 S2 never settles long enough.
    vcount = 0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk); p2[2] = ~p2[2];
      @(negedge clk);
    end
    p2 = 3'b000;
    repeat (12) @(negedge clk);
    chk("bounce_p2", score_p2, 0);
    chk("bounce_pulses", vcount, 0);

    // Priority within a player, concurrency across players.
    vcount = 0;
    @(negedge clk); p1 = 3'b111; p2 = 3'b010;
    repeat (7) @(posedge clk); #1;
    chk("prio_before", score_p1, 1);
    @(posedge clk); #1;
    chk("prio_p1", score_p1, 4);
    chk("prio_p2", score_p2, 2);
    repeat (10) @(negedge clk); p1 = 3'b000; p2 = 3'b000;
    repeat (10) @(negedge clk);
    chk("prio_pulses", vcount, 1);

    toss(3'b001, 3'b000);
    chk("pre_reset_p1", score_p1, 5);

    // Mid-game reset; clock_stopped keeps IDLE while a ball sits on S2.
    @(negedge clk); reset_n = 1'b0; cs = 1'b1; p1 = 3'b100;
    #1;
    chk("midrst_p1", score_p1, 0);
    chk("midrst_p2", score_p2, 0);
    chk("midrst_valid", score_valid, 0);
    chk("midrst_over", game_over, 0);
    chk("midrst_winner", winner, 0);
    @(negedge clk); reset_n = 1'b1;
    vcount = 0;
    repeat (12) @(negedge clk);
    chk("idle_discard", score_p1, 0);
    cs = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_held", score_p1, 0);
    p1 = 3'b000;
    repeat (12) @(negedge clk);
    chk("idle_pulses", vcount, 0);
    toss(3'b001, 3'b000);
    chk("replay_p1", score_p1, 1);

    // Saturation at 63.
    repeat (20) toss(3'b100, 3'b000);
    toss(3'b001, 3'b000);
    chk("sat_62", score_p1, 62);
    vcount = 0;
    toss(3'b100, 3'b000);
    chk("sat_63", score_p1, 63);
    chk("sat_pulse", vcount, 1);
    vcount = 0;
    toss(3'b001, 3'b000);
    chk("sat_hold", score_p1, 63);
    chk("sat_no_pulse", vcount, 0);

    // Game end on a tie; the simultaneous P2 hit is discarded.
    do_reset(2);
    repeat (3) toss(3'b100, 3'b100);
    toss(3'b001, 3'b001);
    chk("tie_p1", score_p1, 10);
    chk("tie_p2", score_p2, 10);
    @(negedge clk); p2 = 3'b001;
    repeat (7) @(negedge clk);
    chk("end_before", game_over, 0);
    cs = 1'b1;
    @(posedge clk); #1;
    chk("end_over", game_over, 1);
    chk("end_winner", winner, 3);
    chk("end_p2", score_p2, 10);
    chk("end_valid", score_valid, 0);
    @(negedge clk); p2 = 3'b000;
    repeat (10) @(negedge clk);
    vcount = 0;
    toss(3'b100, 3'b100);
    chk("over_p1", score_p1, 10);
    chk("over_p2", score_p2, 10);
    chk("over_pulses", vcount, 0);
    chk("over_winner", winner, 3);

    // P1 win.
    do_reset(2);
    toss(3'b001, 3'b000);
    @(negedge clk); cs = 1'b1;
    repeat (3) @(negedge clk);
    chk("p1win_over", game_over, 1);
    chk("p1win_winner", winner, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
